sp_ram_burst_ctrl: RTL and testbench
====================================

// Module: sp_ram_burst_ctrl
// PURPOSE
//  Parametrised single-port synchronous RAM with a burst control unit; next generation of the team's cs/wr/oe RAM.
//  Adds a valid/ready command handshake, byte-lane write enables, multi-beat bursts with address wrap, and read backpressure.
//  Sits between a bus-side master (DMA or CPU bridge) and on-chip storage. One operation (read or write burst) runs at a time.
// PARAMETERS
//  ADDR_W  5        address width; DEPTH = 1<<ADDR_W words
//  DATA_W  8        word width; must be a multiple of 8; BE_W = DATA_W/8
//  LEN_W   3        burst length field width; a burst is cmd_len+1 beats (1..2**LEN_W)
// PORTS
//  clk        in   1       single clock; all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  cmd_valid  in   1       command offered
//  cmd_ready  out  1       command accepted when cmd_valid && cmd_ready
//  cmd_wr     in   1       1 = write burst, 0 = read burst
//  cmd_addr   in   ADDR_W  start word address
//  cmd_len    in   LEN_W   beats minus one
//  wr_valid   in   1       write beat offered
//  wr_ready   out  1       write beat accepted when wr_valid && wr_ready
//  wr_data    in   DATA_W  write data
//  wr_be      in   BE_W    byte enables; lane i covers bits [8i+7:8i]
//  rd_valid   out  1       read data valid
//  rd_ready   in   1       read beat consumed when rd_valid && rd_ready
//  rd_data    out  DATA_W  read data; held stable while rd_valid && !rd_ready
//  rd_last    out  1       qualifies the final beat of a read burst
//  busy       out  1       state != IDLE or rd_valid
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1, wr_ready=0, rd_valid=0, rd_last=0, rd_data=0, busy=0; counters 0.
//    The memory array is not cleared. Reset mid-burst abandons the burst; beats already written stay written.
//  FSM states: IDLE, WRITE, READ.
//  IDLE: cmd_ready = !rd_valid. On accept, latch addr and cnt=cmd_len. Next state is WRITE if cmd_wr, else READ.
//  WRITE: wr_ready=1, cmd_ready=0.
//    Each accepted beat writes only the enabled byte lanes of mem[addr]; wr_be=0 is a legal no-op beat that still counts.
//    Then addr<=addr+1 mod DEPTH and cnt<=cnt-1. The beat with cnt==0 returns to IDLE.
//    wr_valid low stalls indefinitely with no timeout.
//  READ: issue a read at addr when !rd_valid || rd_ready (single output register, no bubble under full throughput).
//    Issue at cycle N gives rd_data=mem[addr] and rd_valid=1 at N+1; rd_last=1 iff the issued beat had cnt==0.
//    After each issue: addr+1 mod DEPTH, cnt-1. After the cnt==0 issue go to IDLE.
//    rd_valid then clears on consumption unless a new read issues that cycle.
//  Latency: command accepted at T -> wr_ready at T+1; read: first rd_valid at T+2, then one beat/cycle while rd_ready=1.
//  Throughput: 1 beat/cycle in both directions; one idle cycle between bursts minimum.
//  Wrap-around: address DEPTH-1 is followed by address 0 within a burst.
//  Backpressure: while rd_valid && !rd_ready, rd_data, rd_last, addr and cnt hold; no reads issue.
//  cmd_ready stays 0 until the last read beat is consumed, so read data of successive bursts is never interleaved.
//  wr_valid/wr_be/wr_data are ignored outside WRITE. rd_ready is ignored when rd_valid=0.
//  Read-after-write across bursts returns the new data (the write completes before IDLE).
// STRUCTURE
//  Package sp_ram_pkg: state enum {IDLE, WRITE, READ}; localparams BE_W and DEPTH; a function that merges wr_be lanes.
//  Sub-module sp_ram_core: array DEPTH x DATA_W with per-byte write enables and a registered read port (en, we[BE_W], addr, din, dout).
//  The control FSM, counters and output register stay in sp_ram_burst_ctrl.
// TESTING
//  1. Reset, then write len=3 at addr 4 with data 11,22,33,44 and be all-ones.
//     Read len=3 at addr 4 -> rd_data 11,22,33,44; rd_last only on 44; first rd_valid 2 cycles after accept.
//  2. DATA_W=32: write 0xAABBCCDD at addr 0, then write 0x11223344 with be=4'b0101 -> read back 0xAA22CC44.
//  3. Wrap: write len=2 at addr 30 (ADDR_W=5) with 1,2,3 -> mem[30]=1, mem[31]=2, mem[0]=3; read len=2 at 30 returns 1,2,3.
//  4. Backpressure: read len=3 with rd_ready low on beats 1 and 3 for 2 cycles each.
//     Expect data held stable, no lost or duplicated beat, and cmd_ready=0 until the last beat is consumed.
//  5. Reset mid-write after 2 of 4 beats -> outputs return to reset values next cycle.
//     Later read shows the 2 written words updated and the other 2 unchanged.
//  6. Command offered while busy -> not accepted; wr_valid pulses while IDLE -> memory unchanged.

Source files
------------

// File: rtl/sp_ram_pkg.sv
// sp_ram_pkg: shared types and helpers for the burst-controlled single-port RAM.
//   state_t      control FSM states
//   DEF_*        default geometry (ADDR_W=5, DATA_W=8, LEN_W=3)
//   BE_W, DEPTH  byte-lane count and word count of the default geometry
//   merge_lanes  replaces the enabled byte lanes of a word with new data
package sp_ram_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 3;
    localparam int BE_W       = DEF_DATA_W / 8;
    localparam int DEPTH      = 1 << DEF_ADDR_W;

    // Widest word the lane merge handles; narrower words are cast in and out.
    localparam int MAX_DATA_W = 64;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    function automatic logic [MAX_DATA_W-1:0] merge_lanes(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] r_word;
        r_word = old_word;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) r_word[8*i +: 8] = new_word[8*i +: 8];
        end
        return r_word;
    endfunction

endpackage

// File: rtl/sp_ram_core.sv
// sp_ram_core: DEPTH x DATA_W storage with per-byte write enables and a
// registered read port.
//   i_clk   clock
//   i_rst   synchronous active-high reset (clears the read register only)
//   i_en    access enable
//   i_we    per-byte write enables; all-zero with i_en set is a read
//   i_addr  word address
//   i_din   write data
//   o_dout  read data, updated one cycle after a read, held otherwise
module sp_ram_core
    import sp_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [DATA_W/8-1:0]   i_we,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_din,
    output logic [DATA_W-1:0]     o_dout
);

    logic [DATA_W-1:0] r_mem [1 << ADDR_W];
    logic [DATA_W-1:0] r_dout;

    // Storage is deliberately outside reset: contents survive a controller reset.
    always_ff @(posedge i_clk) begin
        if (i_en && (|i_we)) begin
            r_mem[i_addr] <= DATA_W'(merge_lanes(MAX_DATA_W'(r_mem[i_addr]),
                                                 MAX_DATA_W'(i_din),
                                                 MAX_BE_W'(i_we)));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dout <= '0;
        end else if (i_en && !(|i_we)) begin
            r_dout <= r_mem[i_addr];
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/sp_ram_burst_ctrl.sv
// sp_ram_burst_ctrl: single-port RAM with a burst command interface.
// One read or write burst of cmd_len+1 beats runs at a time; addresses wrap.
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready      command handshake (i_cmd_wr, i_cmd_addr, i_cmd_len)
//   i_wr_valid/o_wr_ready        write beat handshake (i_wr_data, i_wr_be)
//   o_rd_valid/i_rd_ready        read beat handshake (o_rd_data, o_rd_last)
//   o_busy                       burst in progress or read data pending
//
// state    | meaning
// ST_IDLE  | waiting for a command; blocked while a read beat is still pending
// ST_WRITE | accepting write beats until the beat with cnt==0
// ST_READ  | issuing reads into the output register, one per free slot
module sp_ram_burst_ctrl
    import sp_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_wr,
    input  logic [ADDR_W-1:0]     i_cmd_addr,
    input  logic [LEN_W-1:0]      i_cmd_len,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic [DATA_W/8-1:0]   i_wr_be,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic                  o_rd_last,
    output logic                  o_busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_cnt;
    logic                r_rd_valid;
    logic                r_rd_last;

    logic                w_cmd_ready;
    logic                w_wr_ready;
    logic                w_rd_issue;
    logic                w_cmd_fire;
    logic                w_wr_fire;
    logic                w_cnt_zero;
    logic                w_core_en;
    logic [DATA_W/8-1:0] w_core_we;

    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_wr_ready  = 1'b0;
        w_rd_issue  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A leftover read beat blocks new commands so bursts never interleave.
                w_cmd_ready = !r_rd_valid;
                if (w_cmd_ready && i_cmd_valid) begin
                    w_state_nxt = i_cmd_wr ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                w_wr_ready = 1'b1;
                if (i_wr_valid && w_cnt_zero) w_state_nxt = ST_IDLE;
            end
            ST_READ: begin
                // Issue whenever the output register is empty or being drained.
                w_rd_issue = !r_rd_valid || i_rd_ready;
                if (w_rd_issue && w_cnt_zero) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_cmd_fire = w_cmd_ready && i_cmd_valid;
    assign w_wr_fire  = w_wr_ready && i_wr_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr     <= '0;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            if (w_cmd_fire) begin
                r_addr <= i_cmd_addr;
                r_cnt  <= i_cmd_len;
            end else if (w_wr_fire || w_rd_issue) begin
                r_addr <= r_addr + 1'b1;
                r_cnt  <= r_cnt - 1'b1;
            end
            if (w_rd_issue) begin
                r_rd_valid <= 1'b1;
                r_rd_last  <= w_cnt_zero;
            end else if (i_rd_ready) begin
                r_rd_valid <= 1'b0;
                r_rd_last  <= 1'b0;
            end
        end
    end

    // Reset blocks the access in the same cycle so an abandoned burst stops cleanly.
    assign w_core_en = (w_wr_fire || w_rd_issue) && !i_rst;
    assign w_core_we = w_wr_fire ? i_wr_be : '0;

    sp_ram_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_core (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (w_core_en),
        .i_we   (w_core_we),
        .i_addr (r_addr),
        .i_din  (i_wr_data),
        .o_dout (o_rd_data)
    );

    assign o_cmd_ready = w_cmd_ready;
    assign o_wr_ready  = w_wr_ready;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_last   = r_rd_last;
    assign o_busy      = (r_state != ST_IDLE) || r_rd_valid;

endmodule

// File: tb/tb_sp_ram_burst_ctrl.sv
module tb_sp_ram_burst_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int LW = 3;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic [BW-1:0] wr_be;
    logic          rd_valid, rd_ready, rd_last, busy;
    logic [DW-1:0] rd_data;

    sp_ram_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_wr(cmd_wr),
        .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data), .i_wr_be(wr_be),
        .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data), .o_rd_last(rd_last),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: memory image, beats still owed per direction,
    // and the queue of read beats ({last, data}) the bus must see in order.
    logic [DW-1:0] m_mem [1 << AW];
    int            m_wr_left = 0;
    int            m_pend    = 0;
    bit            m_gap     = 1'b0;
    logic [AW-1:0] m_waddr   = '0;
    logic [DW:0]   m_rdq [$];
    logic [DW-1:0] got [$];

    bit            mc_rdy, mc_vld;
    logic [DW:0]   mc_ent;

    always @(posedge clk) begin
        if (rst) begin
            m_wr_left = 0;
            m_pend    = 0;
            m_gap     = 1'b0;
            m_rdq.delete();
        end else begin
            mc_rdy = (m_wr_left == 0) && (m_pend == 0);
            mc_vld = (m_pend > 0) && !m_gap;
            if (m_wr_left > 0 && wr_valid) begin
                for (int i = 0; i < BW; i++)
                    if (wr_be[i]) m_mem[m_waddr][8*i +: 8] = wr_data[8*i +: 8];
                m_waddr++;
                m_wr_left--;
            end
            if (mc_vld && rd_ready) begin
                void'(m_rdq.pop_front());
                m_pend--;
            end
            m_gap = 1'b0;
            if (mc_rdy && cmd_valid) begin
                if (cmd_wr) begin
                    m_wr_left = int'(cmd_len) + 1;
                    m_waddr   = cmd_addr;
                end else begin
                    for (int k = 0; k <= int'(cmd_len); k++) begin
                        mc_ent = {(k == int'(cmd_len)), m_mem[AW'(int'(cmd_addr) + k)]};
                        m_rdq.push_back(mc_ent);
                    end
                    m_pend = int'(cmd_len) + 1;
                    m_gap  = 1'b1;
                end
            end
        end
    end

    bit ck_v, ck_r;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            ck_r = (m_wr_left == 0) && (m_pend == 0);
            ck_v = (m_pend > 0) && !m_gap;
            check("cmd_ready", DW'(cmd_ready), DW'(ck_r));
            check("wr_ready", DW'(wr_ready), DW'(m_wr_left > 0));
            check("busy", DW'(busy), DW'(!ck_r));
            check("rd_valid", DW'(rd_valid), DW'(ck_v));
            if (ck_v && m_rdq.size() > 0) begin
                check("rd_data", rd_data, m_rdq[0][DW-1:0]);
                check("rd_last", DW'(rd_last), DW'(m_rdq[0][DW]));
            end
            if (rd_valid === 1'b1 && rd_ready === 1'b1) got.push_back(rd_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input bit wr, input int addr, input int len);
        int n;
        n = 0;
        cmd_wr    = wr;
        cmd_addr  = AW'(addr);
        cmd_len   = LW'(len);
        cmd_valid = 1'b1;
        while (!(m_wr_left == 0 && m_pend == 0) && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) check("cmd_timeout", DW'(n), 0);
        tick();
        cmd_valid = 1'b0;
        cmd_wr    = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_len   = LW'($urandom);
    endtask

    logic [DW-1:0] bd [8];
    logic [BW-1:0] bb [8];

    task automatic wr_beats(input int first, input int last, input int stall_max);
        for (int i = first; i <= last; i++) begin
            repeat ($urandom_range(0, stall_max)) begin
                wr_valid = 1'b0;
                wr_data  = $urandom;
                tick();
            end
            wr_valid = 1'b1;
            wr_data  = bd[i];
            wr_be    = bb[i];
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic write_burst(input int addr, input int len, input int stall_max);
        send_cmd(1'b1, addr, len);
        wr_beats(0, len, stall_max);
    endtask

    // mode 0: always ready; 1: random ready; 2: stall beats 0 and 2 for two cycles each
    task automatic rd_drain(input int mode);
        int n, total, beat;
        int st [8];
        n = 0;
        total = m_pend;
        for (int i = 0; i < 8; i++) st[i] = 0;
        while (m_pend > 0 && n < 300) begin
            beat = total - m_pend;
            case (mode)
                0: rd_ready = 1'b1;
                1: rd_ready = ($urandom_range(0, 9) < 7);
                default: begin
                    rd_ready = 1'b1;
                    if (!m_gap && (beat == 0 || beat == 2) && st[beat] < 2) begin
                        rd_ready = 1'b0;
                        st[beat]++;
                    end
                end
            endcase
            tick();
            n++;
        end
        if (n == 300) check("rd_timeout", DW'(n), 0);
        rd_ready = 1'($urandom);
    endtask

    task automatic read_burst(input int addr, input int len, input int mode);
        got.delete();
        send_cmd(1'b0, addr, len);
        rd_drain(mode);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; wr_be = '0; rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", DW'(cmd_ready), 1);
        check("rst_wr_ready", DW'(wr_ready), 0);
        check("rst_rd_valid", DW'(rd_valid), 0);
        check("rst_rd_last", DW'(rd_last), 0);
        check("rst_busy", DW'(busy), 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b0;

        // Fill the whole array with a known pattern.
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                bd[i] = 32'hC0DE0000 | 32'(b * 8 + i);
                bb[i] = '1;
            end
            write_burst(b * 8, 7, 1);
        end

        // Basic write then read with latency checks.
        bd[0] = 32'h11; bd[1] = 32'h22; bd[2] = 32'h33; bd[3] = 32'h44;
        for (int i = 0; i < 4; i++) bb[i] = '1;
        send_cmd(1'b1, 4, 3);
        check("t1_wr_ready_lat", DW'(wr_ready), 1);
        wr_beats(0, 3, 0);
        got.delete();
        rd_ready = 1'b1;
        send_cmd(1'b0, 4, 3);
        check("t1_rd_lat_t1", DW'(rd_valid), 0);
        tick();
        check("t1_rd_lat_t2", DW'(rd_valid), 1);
        check("t1_first_data", rd_data, 32'h11);
        rd_drain(0);
        check("t1_beats", DW'(got.size()), 4);
        if (got.size() == 4) begin
            check("t1_d0", got[0], 32'h11);
            check("t1_d1", got[1], 32'h22);
            check("t1_d2", got[2], 32'h33);
            check("t1_d3", got[3], 32'h44);
        end

        // Byte-lane merge.
        bd[0] = 32'hAABBCCDD; bb[0] = 4'hF;
        write_burst(0, 0, 0);
        bd[0] = 32'h11223344; bb[0] = 4'b0101;
        write_burst(0, 0, 0);
        read_burst(0, 0, 0);
        check("t2_merge", (got.size() == 1) ? got[0] : 'x, 32'hAA22CC44);

        // Wrap-around.
        bd[0] = 32'd1; bd[1] = 32'd2; bd[2] = 32'd3;
        for (int i = 0; i < 3; i++) bb[i] = '1;
        write_burst(30, 2, 0);
        read_burst(30, 2, 0);
        check("t3_beats", DW'(got.size()), 3);
        if (got.size() == 3) begin
            check("t3_d30", got[0], 32'd1);
            check("t3_d31", got[1], 32'd2);
            check("t3_d0", got[2], 32'd3);
        end

        // Backpressure on beats 1 and 3.
        read_burst(4, 3, 2);
        check("t4_beats", DW'(got.size()), 4);
        if (got.size() == 4) begin
            check("t4_d0", got[0], 32'h11);
            check("t4_d1", got[1], 32'h22);
            check("t4_d2", got[2], 32'h33);
            check("t4_d3", got[3], 32'h44);
        end

        // Command offered during a write burst must wait; wr_valid in IDLE is ignored.
        for (int i = 0; i < 4; i++) begin bd[i] = 32'h5A5A0000 | 32'(i); bb[i] = '1; end
        send_cmd(1'b1, 16, 3);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 5'd0; cmd_len = 3'd0;
        wr_beats(0, 2, 1);
        cmd_valid = 1'b0;
        wr_beats(3, 3, 0);
        repeat (5) begin
            wr_valid = 1'b1; wr_data = $urandom; wr_be = '1;
            tick();
        end
        wr_valid = 1'b0;
        read_burst(4, 3, 0);
        check("t6_idle_d0", (got.size() == 4) ? got[0] : 'x, 32'h11);
        check("t6_idle_d3", (got.size() == 4) ? got[3] : 'x, 32'h44);
        read_burst(16, 3, 1);
        check("t6_busy_d0", (got.size() == 4) ? got[0] : 'x, 32'h5A5A0000);

        // Reset after two of four write beats.
        bd[0] = 32'hA1; bd[1] = 32'hA2; bb[0] = '1; bb[1] = '1;
        send_cmd(1'b1, 8, 3);
        wr_beats(0, 1, 0);
        rst = 1'b1;
        tick();
        check("t5_cmd_ready", DW'(cmd_ready), 1);
        check("t5_wr_ready", DW'(wr_ready), 0);
        check("t5_rd_valid", DW'(rd_valid), 0);
        check("t5_busy", DW'(busy), 0);
        check("t5_rd_data", rd_data, 0);
        rst = 1'b0;
        tick();
        read_burst(8, 3, 0);
        check("t5_beats", DW'(got.size()), 4);
        if (got.size() == 4) begin
            check("t5_d8", got[0], 32'hA1);
            check("t5_d9", got[1], 32'hA2);
            check("t5_d10", got[2], 32'hC0DE000A);
            check("t5_d11", got[3], 32'hC0DE000B);
        end

        // Randomised bursts against the model.
        for (int it = 0; it < 150; it++) begin
            int a, l;
            a = $urandom_range(0, (1 << AW) - 1);
            l = $urandom_range(0, (1 << LW) - 1);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 8; i++) begin
                    bd[i] = $urandom;
                    bb[i] = BW'($urandom);
                end
                write_burst(a, l, 2);
            end else begin
                read_burst(a, l, 1);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
